// File: rtl/pipelined_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: C = A - B - Bin, CHUNK bits per cycle,
// least-significant chunk first, through a single shared chunk subtractor.
// Returns {borrow_out, difference}; the caller decides on modulus add-back.

// One CHUNK-bit subtract slice: {carry, diff} = a + ~b + ~bin, borrow = ~carry.
module chunk_sub #(
  parameter int CHUNK = 128
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             bin,
  output logic [CHUNK-1:0] diff,
  output logic             bout
);
  logic carry;

  // Subtraction as addition of the one's complement plus the inverted borrow.
  always_comb begin
    {carry, diff} = {1'b0, a} + {1'b0, ~b} + {{CHUNK{1'b0}}, ~bin};
  end

  assign bout = ~carry;
endmodule

module pipelined_subtractor #(
  parameter int WIDTH = 384,
  parameter int CHUNK = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             Bin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH:0]   C,
  output logic             done,
  output logic             busy
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q;     // operands, shifted right one chunk per cycle
  logic [WIDTH-1:0] res_q;        // result shift register, chunks enter MSB-side
  logic             borrow_q;     // borrow carried between chunks
  logic [WIDTH:0]   c_q;
  logic             done_q;

  logic [CHUNK-1:0] diff;
  logic             bout;
  logic             last;

  assign last = (cnt_q == CW'(NCHUNK - 1));

  // The only subtractor: always works on the low chunk of the operand shifters.
  chunk_sub #(.CHUNK(CHUNK)) u_sub (
    .a    (a_q[CHUNK-1:0]),
    .b    (b_q[CHUNK-1:0]),
    .bin  (borrow_q),
    .diff (diff),
    .bout (bout)
  );

  // State register; reset wins over any start in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: start is only looked at in IDLE, so a start while busy is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: busy follows RUN; the done cycle is already IDLE so they never overlap.
  always_comb begin
    busy = (state_q == RUN);
  end

  // Datapath: latch on start, one chunk per RUN cycle, publish C only at the end.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      c_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q      <= A;
            b_q      <= B;
            borrow_q <= Bin;
            cnt_q    <= '0;
          end
        end
        RUN: begin
          a_q      <= a_q >> CHUNK;
          b_q      <= b_q >> CHUNK;
          borrow_q <= bout;
          res_q    <= {diff, res_q[WIDTH-1:CHUNK]};
          cnt_q    <= cnt_q + CW'(1);
          if (last) begin
            // Final chunk goes straight to C so partial results never show.
            c_q    <= {bout, diff, res_q[WIDTH-1:CHUNK]};
            done_q <= 1'b1;
            cnt_q  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign C    = c_q;
  assign done = done_q;
endmodule

// File: tb/tb_pipelined_subtractor.sv
// Scoreboard bench for pipelined_subtractor: stimulus pushes expected results
// (plain 385-bit arithmetic) with their due cycle; a negedge monitor checks
// done/busy/C every cycle against the queue.
module tb_pipelined_subtractor;
  localparam int W = 384;

  logic         clk = 1'b0;
  logic         rst, start, Bin;
  logic [W-1:0] A, B;
  logic [W:0]   C;
  logic         done, busy;

  typedef struct {
    logic [W:0] val;
    int         dc;
  } exp_t;

  exp_t       q[$];
  logic [W:0] c_hold;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;

  pipelined_subtractor #(.WIDTH(W), .CHUNK(128)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .Bin   (Bin),
    .A     (A),
    .B     (B),
    .C     (C),
    .done  (done),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd384();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Called at posedge+1; start is sampled at the next edge, done due 4 cycles on.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                       input bit accept);
    exp_t e;
    A = a; B = b; Bin = bi; start = 1'b1;
    if (accept) begin
      e.val = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
      e.dc  = cyc + 4;
      q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
    A = rnd384(); B = rnd384(); Bin = 1'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: due-cycle done, busy window, and C held between completions.
  always @(negedge clk) begin
    if (mon_en) begin
      bit exp_done, exp_busy;
      exp_done = (q.size() > 0) && (q[0].dc == cyc);
      exp_busy = (q.size() > 0) && (cyc > q[0].dc - 4) && (cyc < q[0].dc);
      chk("done", {{W{1'b0}}, done}, {{W{1'b0}}, exp_done});
      chk("busy", {{W{1'b0}}, busy}, {{W{1'b0}}, exp_busy});
      if (exp_done) begin
        chk("result", C, q[0].val);
        c_hold = q[0].val;
        void'(q.pop_front());
      end else begin
        chk("C_hold", C, c_hold);
      end
      if (rst) c_hold = '0;
    end
  end

  initial begin
    logic [W-1:0] x, one;
    one = {{(W-1){1'b0}}, 1'b1};
    rst = 1'b1; start = 1'b0; Bin = 1'b0; A = '0; B = '0;
    idle(3);
    @(negedge clk);
    chk("rst_C", C, '0);
    chk("rst_done", {{W{1'b0}}, done}, '0);
    chk("rst_busy", {{W{1'b0}}, busy}, '0);
    @(posedge clk); #1;
    rst = 1'b0; c_hold = '0; mon_en = 1'b1;
    idle(1);

    // Directed arithmetic cases
    issue(384'd5, 384'd3, 1'b0, 1'b1);          idle(4);
    issue('0, one, 1'b0, 1'b1);                 idle(4);
    issue(one << 128, one, 1'b0, 1'b1);         idle(4);
    issue(one << 256, one, 1'b0, 1'b1);         idle(4);
    x = rnd384();
    issue(x, x, 1'b1, 1'b1);                    idle(4);
    issue(x, x, 1'b0, 1'b1);                    idle(4);
    issue('1, '0, 1'b1, 1'b1);                  idle(4);

    // Start while busy is ignored; then a start exactly in the done cycle
    issue(rnd384(), rnd384(), 1'b0, 1'b1);
    issue(384'd77, 384'd99, 1'b1, 1'b0);
    idle(2);
    issue(384'd10, 384'd4, 1'b0, 1'b1);
    idle(3);
    issue(rnd384(), rnd384(), 1'b1, 1'b1);      idle(5);

    // Reset two edges after start aborts; a following start completes
    issue(rnd384(), rnd384(), 1'b0, 1'b1);
    idle(1);
    rst = 1'b1;
    @(posedge clk); #1;
    q.delete(); rst = 1'b0;
    idle(2);
    issue(384'd1000, 384'd1, 1'b0, 1'b1);       idle(5);

    // Reset and start together: start dropped
    rst = 1'b1; start = 1'b1; A = 384'd9; B = 384'd2;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    idle(6);

    // Randomized traffic with busy-time junk starts and variable gaps
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra, rb;
      int gap;
      ra = rnd384(); rb = rnd384();
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: ra = ra & ~(('1) << 130);
        default: ;
      endcase
      issue(ra, rb, 1'($urandom), 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        issue(rnd384(), rnd384(), 1'($urandom), 1'b0);
        idle(2);
      end else begin
        idle(3);
      end
      gap = $urandom_range(0, 2);
      idle(gap);
    end

    idle(8);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending: %0d results never completed", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout: simulation did not finish within bound");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
